// File: rtl/write_once_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : write_once_bank_arbiter
// Purpose  : Round-robin arbitration of NUM_REQ requesters onto one bank of
//            write-once registers. Each register locks on its first write.
// Revision : 1.0 - initial release
// ============================================================================
module write_once_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16
) (
  input  logic                        Clk,
  input  logic                        ip_reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        resp_valid,
  output logic [2:0]                  resp_id,
  output logic                        resp_err,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic [2**ADDR_W-1:0]        lock_status,
  output logic                        busy
);

  localparam int               c_PTR_W   = $clog2(NUM_REQ);
  localparam int               c_NREG    = 2**ADDR_W;
  localparam logic [c_PTR_W:0] c_NUM_REQ = (c_PTR_W+1)'(NUM_REQ);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_REQ-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0]   r_gnt;
  logic                 r_wr;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [2:0]           r_id;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_err;
  logic                 r_resp_valid;
  logic [2:0]           r_resp_id;
  logic                 r_resp_err;
  logic [DATA_W-1:0]    r_resp_rdata;
  logic [DATA_W-1:0]    r_mem [c_NREG];
  logic [c_NREG-1:0]    r_lock;

  logic [2*NUM_REQ-1:0] w_req_rot;
  logic [c_PTR_W:0]     w_sum;
  logic [c_PTR_W-1:0]   w_win;
  logic [c_PTR_W-1:0]   w_ptr_nxt;
  logic                 w_any;
  logic                 w_sel_wr;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;

  // Round-robin winner: rotate requests so rr_ptr sits at bit 0, take the
  // lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    w_req_rot = {req, req} >> r_rr_ptr;
    w_any     = |req;
    w_sum     = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_sum = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
      end
    end
    if (w_sum >= c_NUM_REQ) begin
      w_sum = w_sum - c_NUM_REQ;
    end
    w_win     = w_sum[c_PTR_W-1:0];
    w_ptr_nxt = (w_win == c_LAST) ? '0 : w_win + 1'b1;
  end

  // Command fields of the current winner.
  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (c_PTR_W'(k) == w_win) begin
        w_sel_wr    = req_write[k];
        w_sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (ip_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: IDLE waits for any request, ACCESS and RESP last one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: grant/latch in IDLE, bank access in ACCESS, response in RESP.
  always_ff @(posedge Clk) begin
    if (ip_reset) begin
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_id         <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_lock       <= '0;
      for (int i = 0; i < c_NREG; i++) r_mem[i] <= '0;
    end else begin
      r_gnt        <= '0;
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt    <= NUM_REQ'(1) << w_win;
            r_rr_ptr <= w_ptr_nxt;
            r_id     <= 3'(w_win);
            r_wr     <= w_sel_wr;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
          end
        end
        S_ACCESS: begin
          r_rdata <= r_mem[r_addr];
          r_err   <= 1'b0;
          if (r_wr) begin
            if (r_lock[r_addr]) begin
              r_err <= 1'b1;
            end else begin
              r_mem[r_addr]  <= r_wdata;
              r_lock[r_addr] <= 1'b1;
            end
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_id    <= r_id;
          r_resp_err   <= r_err;
          r_resp_rdata <= r_rdata;
        end
        default: ;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign lock_status = r_lock;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_write_once_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_once_bank_arbiter
// Purpose  : Directed self-checking bench for write_once_bank_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_once_bank_arbiter;

  localparam int c_N  = 4;
  localparam int c_AW = 3;
  localparam int c_DW = 16;

  logic                  Clk = 1'b0;
  logic                  ip_reset;
  logic [c_N-1:0]        req;
  logic [c_N-1:0]        req_write;
  logic [c_N*c_AW-1:0]   req_addr;
  logic [c_N*c_DW-1:0]   req_wdata;
  logic [c_N-1:0]        gnt;
  logic                  resp_valid;
  logic [2:0]            resp_id;
  logic                  resp_err;
  logic [c_DW-1:0]       resp_rdata;
  logic [7:0]            lock_status;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;

  write_once_bank_arbiter #(.NUM_REQ(c_N), .ADDR_W(c_AW), .DATA_W(c_DW)) u_dut (
    .Clk(Clk), .ip_reset(ip_reset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .lock_status(lock_status), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Single comparison point: counts every vector and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one command from requester id while the DUT is idle and check the
  // grant one cycle later and the response three cycles later.
  task automatic do_txn(input int id, input logic wr, input logic [2:0] addr,
                        input logic [15:0] wdata, input logic exp_err,
                        input logic [15:0] exp_rdata, input logic [7:0] exp_lock,
                        input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = 4'(1 << id);
    req            = '0;
    req[id]        = 1'b1;
    req_write[id]  = wr;
    req_addr[id*c_AW +: c_AW]  = addr;
    req_wdata[id*c_DW +: c_DW] = wdata;
    step();
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    req = '0;
    step();
    chk({tag, ".no_early_valid"}, 32'(resp_valid), 32'd0);
    step();
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".id"},    32'(resp_id),    32'(id));
    chk({tag, ".err"},   32'(resp_err),   32'(exp_err));
    chk({tag, ".rdata"}, 32'(resp_rdata), 32'(exp_rdata));
    chk({tag, ".lock"},  32'(lock_status), 32'(exp_lock));
  endtask

  initial begin
    int  cyc;
    logic seen_valid;
    ip_reset  = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    step();
    step();
    chk("rst.gnt",   32'(gnt),         32'd0);
    chk("rst.valid", 32'(resp_valid),  32'd0);
    chk("rst.busy",  32'(busy),        32'd0);
    chk("rst.lock",  32'(lock_status), 32'd0);
    chk("rst.rdata", 32'(resp_rdata),  32'd0);
    ip_reset = 1'b0;

    // First write locks addr 2; a second write is rejected; read sees first value.
    do_txn(1, 1'b1, 3'd2, 16'h00A5, 1'b0, 16'h0000, 8'h04, "wr1");
    do_txn(3, 1'b1, 3'd2, 16'h1234, 1'b1, 16'h00A5, 8'h04, "wr_locked");
    do_txn(0, 1'b0, 3'd2, 16'h0000, 1'b0, 16'h00A5, 8'h04, "rd2");
    // Unwritten address reads zero and stays unlocked.
    do_txn(1, 1'b0, 3'd7, 16'h0000, 1'b0, 16'h0000, 8'h04, "rd7");
    // rr_ptr is 2 here; a grant to 2 moves it to 3, then the wrap search
    // from 3 must still find requester 2.
    do_txn(2, 1'b0, 3'd2, 16'h0000, 1'b0, 16'h00A5, 8'h04, "rd_r2");
    do_txn(2, 1'b0, 3'd2, 16'h0000, 1'b0, 16'h00A5, 8'h04, "wrap_r2");

    // Reset during ACCESS of a write to addr 5 aborts it.
    req       = 4'b1000;
    req_write = 4'b1000;
    req_addr[3*c_AW +: c_AW]  = 3'd5;
    req_wdata[3*c_DW +: c_DW] = 16'hBEEF;
    step();
    chk("abort.gnt",  32'(gnt),  32'h8);
    chk("abort.busy_access", 32'(busy), 32'd1);
    req      = '0;
    ip_reset = 1'b1;
    step();
    ip_reset = 1'b0;
    chk("abort.busy", 32'(busy),        32'd0);
    chk("abort.lock", 32'(lock_status), 32'd0);
    seen_valid = resp_valid;
    for (int i = 0; i < 3; i++) begin
      step();
      seen_valid = seen_valid | resp_valid;
    end
    chk("abort.no_valid", 32'(seen_valid), 32'd0);
    // rr_ptr is 0 after reset; only requester 3 asks, so it wins and rr_ptr returns to 0.
    do_txn(3, 1'b0, 3'd5, 16'h0000, 1'b0, 16'h0000, 8'h00, "rd5_after_abort");

    // All four requesters held high: grants 0,1,2,3,0, three cycles apart.
    req       = 4'hF;
    req_write = '0;
    for (int g = 0; g < 5; g++) begin
      cyc = 0;
      do begin
        step();
        cyc++;
      end while (gnt == '0 && cyc < 10);
      chk($sformatf("rr.gnt%0d", g), 32'(gnt), 32'(1 << (g % 4)));
      chk($sformatf("rr.gap%0d", g), 32'(cyc), (g == 0) ? 32'd1 : 32'd3);
    end
    req = '0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/write_once_bank_arbiter.md
Name: write_once_bank_arbiter

Overview:
- Shares one bank of write-once 16-bit registers between NUM_REQ requesters.
- Round-robin arbiter plus a small FSM: grants one requester at a time, executes its read or write, returns a response.
- Each register locks on its first successful write after reset. Later writes to it are rejected with an error.
- Sits between bus-side requesters and the write-once status/data registers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 3, register address width; bank holds 2**ADDR_W registers
- DATA_W, 16, register data width

Ports:
- Clk  input  1  clock; all logic on rising edge
- ip_reset  input  1  synchronous active-high reset
- req  input  NUM_REQ  per-requester request; held high until its gnt bit is seen
- req_write  input  NUM_REQ  per-requester op: 1 = write, 0 = read
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data; same packing
- gnt  output  NUM_REQ  one-hot grant, single-cycle pulse
- resp_valid  output  1  single-cycle response strobe
- resp_id  output  3  index of the requester being answered
- resp_err  output  1  write rejected because the register was already locked
- resp_rdata  output  DATA_W  read data (current value for a read; pre-existing value for a write)
- lock_status  output  2**ADDR_W  per-register lock bit
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (ip_reset high at an edge), effective next cycle:
  - all registers = 0, all lock bits = 0, rr_ptr = 0, state = IDLE
  - gnt, resp_valid, resp_id, resp_err, resp_rdata, busy = 0
  - reset wins over every other event, including a transaction in flight: that transaction is aborted, no resp_valid is issued, and no register or lock bit is updated.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If req != 0, select the winner: the first set bit searching upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
  - Latch the winner's op, addr and wdata into internal registers.
  - Pulse gnt[winner] for exactly one cycle.
  - Set rr_ptr = (winner+1) mod NUM_REQ.
  - Go to ACCESS.
  - If req == 0, stay in IDLE; gnt stays 0.
- ACCESS (one cycle), using only the latched command:
  - Capture rdata = reg[addr].
  - Write with lock[addr] = 0: reg[addr] = wdata, lock[addr] = 1, err = 0.
  - Write with lock[addr] = 1: no update, err = 1.
  - Read: err = 0.
  - Go to RESP.
- RESP (one cycle):
  - resp_valid = 1; resp_id, resp_err and resp_rdata driven from the latched values.
  - Return to IDLE. The next arbitration happens in the IDLE cycle after RESP, so there is no back-to-back grant.
- Latency: req sampled at edge N -> gnt high in cycle N+1 -> resp_valid high in cycle N+3. Throughput is one transaction per 3 cycles.
- Requesters:
  - Must drop req (or present a new command) the cycle after gnt.
  - A req still high on the next IDLE sample is treated as a new request.
  - Changes to req or command inputs during ACCESS/RESP have no effect.
- resp_rdata, resp_id and resp_err hold their last values when resp_valid = 0. Only resp_valid qualifies them.
- A register's value and lock bit change only on an accepted write. Locks clear only on ip_reset.
- A write and a read to the same address never coexist, since only one transaction is in flight.
- Address is always in range: the bank is exactly 2**ADDR_W registers.

Test Plan:
- Reset, then requester 1 writes 0x00A5 to addr 2 -> gnt = 4'b0010 at cycle+1, resp_valid at cycle+3 with resp_id = 1, resp_err = 0, resp_rdata = 0x0000, lock_status[2] = 1.
- Requester 3 then writes 0x1234 to addr 2 -> resp_err = 1; a subsequent read of addr 2 returns 0x00A5.
- All four req held high continuously from rr_ptr = 0 -> grants in order 0, 1, 2, 3, 0, each 3 cycles apart; no requester is granted twice before all others are served.
- Only requester 2 active while rr_ptr = 3 -> wrap search grants 2; rr_ptr becomes 3.
- ip_reset asserted in the ACCESS cycle of a write to addr 5 -> no resp_valid; reg[5] = 0, lock_status = 0, busy = 0 the next cycle.
- Read of an unwritten addr 7 -> resp_rdata = 0x0000, resp_err = 0, lock_status[7] stays 0.
